// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: requester ids, default
// depth and the access legality check.
package dmem_arbiter_pkg;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DBG = 1'b1
   } req_id_e;

   localparam int unsigned DEPTH_DEFAULT = 20;

   // Word aligned and inside the implemented words.
   function automatic logic addr_legal(input logic [31:0] addr, input int unsigned depth);
      return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a bounded lock: the last winner may keep
// the grant while it locks, up to MAX_HOLD consecutive grants.
module dmem_arbiter_rr_arb2
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [1:0] lock,
   output logic [1:0] gnt
);

   localparam int unsigned HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_SAT = HW'(MAX_HOLD);

   logic          last;
   logic [HW-1:0] hold_cnt;
   logic          gnt_id;

   always_comb begin
      gnt = '0;
      unique case (req)
         2'b01: gnt[REQ_CPU] = 1'b1;
         2'b10: gnt[REQ_DBG] = 1'b1;
         2'b11: begin
            if (lock[last] && (hold_cnt < HOLD_SAT)) begin
               gnt[last] = 1'b1;
            end else begin
               gnt[~last] = 1'b1;
            end
         end
         default: gnt = '0;
      endcase
   end

   assign gnt_id = gnt[REQ_DBG];

   // Counter keeps running while the other side is idle; saturation is what
   // hands the grant over as soon as the waiter shows up.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last     <= REQ_DBG;
         hold_cnt <= '0;
      end else if (|gnt) begin
         if (gnt_id == last) begin
            hold_cnt <= (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + HW'(1);
         end else begin
            last     <= gnt_id;
            hold_cnt <= HW'(1);
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU MEM stage (r0) and
// the debug/DMA loader (r1); illegal accesses are answered with an error.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH    = DEPTH_DEFAULT,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        r0_req,
   input  logic        r0_we,
   input  logic [31:0] r0_addr,
   input  logic [31:0] r0_wdata,
   input  logic        r0_lock,
   output logic        r0_gnt,
   output logic        r0_rvalid,
   output logic [31:0] r0_rdata,
   output logic        r0_err,
   input  logic        r1_req,
   input  logic        r1_we,
   input  logic [31:0] r1_addr,
   input  logic [31:0] r1_wdata,
   input  logic        r1_lock,
   output logic        r1_gnt,
   output logic        r1_rvalid,
   output logic [31:0] r1_rdata,
   output logic        r1_err,
   output logic [31:0] address,
   output logic [31:0] write_data,
   output logic        MemWrite,
   output logic        MemRead,
   input  logic [31:0] read_data
);

   logic [1:0]  gnt;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_legal;
   logic        rd_ok;

   dmem_arbiter_rr_arb2 #(
      .MAX_HOLD (MAX_HOLD)
   ) u_arb (
      .clk  (clk),
      .rst  (rst),
      .req  ({r1_req, r0_req}),
      .lock ({r1_lock, r0_lock}),
      .gnt  (gnt)
   );

   assign r0_gnt = gnt[REQ_CPU];
   assign r1_gnt = gnt[REQ_DBG];

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      if (gnt[REQ_CPU]) begin
         sel_we    = r0_we;
         sel_addr  = r0_addr;
         sel_wdata = r0_wdata;
      end else if (gnt[REQ_DBG]) begin
         sel_we    = r1_we;
         sel_addr  = r1_addr;
         sel_wdata = r1_wdata;
      end
      sel_legal = (|gnt) && addr_legal(sel_addr, DEPTH);
      rd_ok     = sel_legal && !sel_we;
   end

   assign address    = sel_addr;
   assign write_data = sel_wdata;
   assign MemWrite   = sel_legal && sel_we;
   assign MemRead    = rd_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r0_rvalid <= 1'b0;
         r0_err    <= 1'b0;
         r0_rdata  <= '0;
         r1_rvalid <= 1'b0;
         r1_err    <= 1'b0;
         r1_rdata  <= '0;
      end else begin
         r0_rvalid <= gnt[REQ_CPU];
         r0_err    <= gnt[REQ_CPU] && !sel_legal;
         r0_rdata  <= (gnt[REQ_CPU] && rd_ok) ? read_data : '0;
         r1_rvalid <= gnt[REQ_DBG];
         r1_err    <= gnt[REQ_DBG] && !sel_legal;
         r1_rdata  <= (gnt[REQ_DBG] && rd_ok) ? read_data : '0;
      end
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-ported data memory between requester 0 (CPU MEM stage) and requester 1 (debug/DMA loader).
- Round-robin arbitration with bounded lock bursts; illegal addresses are rejected before they reach memory.
- Read data is captured into registered per-requester responses, so downstream logic never sees the memory's combinational read path.
- Sits between the pipeline/debug ports and the data memory instance.

Parameters:
DEPTH, 20, number of implemented 32-bit words; legal word index is 0..DEPTH-1.
MAX_HOLD, 4, maximum consecutive grants to a locking requester while the other requester waits (minimum 1).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
r0_req  in  1  requester 0 access request
r0_we  in  1  requester 0 write (1) / read (0)
r0_addr  in  32  requester 0 byte address
r0_wdata  in  32  requester 0 write data
r0_lock  in  1  requester 0 asks to keep the grant next cycle
r0_gnt  out  1  requester 0 accepted this cycle (combinational)
r0_rvalid  out  1  requester 0 response valid (registered pulse)
r0_rdata  out  32  requester 0 read data (registered)
r0_err  out  1  requester 0 error response (registered, qualifies r0_rvalid)
r1_req, r1_we, r1_addr, r1_wdata, r1_lock, r1_gnt, r1_rvalid, r1_rdata, r1_err  same as r0_* for requester 1
address  out  32  memory byte address
write_data  out  32  memory write data
MemWrite  out  1  memory write enable
MemRead  out  1  memory read enable
read_data  in  32  memory read data (combinational from address)

Behaviour:
- State: last (1 bit, id of the last granted requester), hold_cnt (width clog2(MAX_HOLD+1)).
- Reset (rst=0, async):
  - last=1, so r0 wins the first contention.
  - hold_cnt=0.
  - All rX_rvalid, rX_err, rX_rdata = 0.
  - A response pending at reset is dropped.
- Grant is combinational, evaluated every cycle:
  - Only one requester active: grant it.
  - Both active, lock honoured: grant last when r<last>_lock=1 and hold_cnt<MAX_HOLD.
  - Both active otherwise: grant !last.
  - Neither active: no grant; last and hold_cnt hold.
- Grant bookkeeping, at posedge on any grant g:
  - g==last: hold_cnt=min(hold_cnt+1, MAX_HOLD).
  - g!=last: last=g, hold_cnt=1.
  - Lock is ignored when the other requester is idle; hold_cnt still counts, and the saturation gives the waiter priority once it requests.
- Legality of the granted access: addr[1:0]==0 and addr[31:2]<DEPTH. Word index = addr[31:2]; the memory itself decodes addr[6:2].
- Memory drive:
  - address/write_data always forward the granted requester's fields (0 when no grant).
  - MemWrite = grant & legal & we.
  - MemRead = grant & legal & !we.
- Response, on the posedge ending a granted cycle, granted requester only:
  - rvalid=1.
  - err = !legal.
  - rdata = read_data for a legal read; 0 for writes and errors.
  - Illegal accesses never assert MemWrite/MemRead.
  - The ungranted requester's rvalid is 0.
- Latency: 1 cycle from grant to rvalid. Throughput: 1 access per cycle in total.
- Back-to-back: the same requester can be granted every cycle; rvalid stays high continuously with a new rdata each cycle.
- Read-after-write, same address, consecutive cycles: the read returns the new data, because the memory write commits on the same edge.
- A requester must hold req/we/addr/wdata stable until it sees gnt.

Decomposition:
- Shared package holds: requester-id constants REQ_CPU=0, REQ_DBG=1; the DEPTH default; the legality-check function.
- One natural sub-module: rr_arb2 (2-way round-robin with lock and hold counter). It outputs the grant vector and owns last/hold_cnt.
- The top level handles the mux, legality checks and response registers.

Test Plan:
1. After reset, r0 reads addr 0x0C (memory word 3=3) → r0_gnt same cycle, MemRead=1; next cycle r0_rvalid=1, r0_rdata=3, r0_err=0.
2. r0 and r1 both request reads every cycle, no lock → grants alternate r0, r1, r0, r1 (r0 first); each rvalid follows its grant by 1 cycle.
3. r1 writes 0xDEAD_BEEF to 0x14 with lock=1 while r0 requests continuously, MAX_HOLD=4 → r1 granted 4 consecutive cycles, then r0; memory word 5 = 0xDEADBEEF.
4. r0 reads 0x02 (misaligned), then 0x50 (index 20 ≥ DEPTH) → MemRead stays 0; next cycle r0_rvalid=1, r0_err=1, r0_rdata=0 for each.
5. r0 writes 0x55 to 0x20, r0 reads 0x20 next cycle → r0_rdata=0x55.
6. rst driven low mid-cycle after a granted read → rvalid/err/rdata go to 0 immediately; after release, first contention grants r0.
